// File: rtl/binary_adder_pkg.sv
// Shared constants and a reference helper for the registered ripple-carry adder.
package binary_adder_pkg;

  // Operand width used when the instantiating block does not override WIDTH.
  localparam int unsigned DEFAULT_WIDTH = 4;

  // Widest operand the adder is expected to be built with.
  localparam int unsigned MAX_WIDTH = 32;

  // Full-precision reference sum for benches.
  // Zero-extends both operands and adds them, so the carry-out lands in bit MAX_WIDTH.
  function automatic logic [MAX_WIDTH:0] ref_sum(input logic [MAX_WIDTH-1:0] a,
                                                 input logic [MAX_WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder: one link of the ripple-carry chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum is the parity of the three inputs; carry is their majority.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/binary_adder.sv
// Registered unsigned adder: WIDTH-bit operands, WIDTH+1-bit sum with the carry as MSB.
// The datapath is a structural ripple chain of full_adder_cell instances.
// Sum, overflow flag and valid are all registered, so there is no input-to-output combinational path.
module binary_adder
  import binary_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH:0]   sum,
  output logic             out_valid,
  output logic             signed_ovf
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] s_bits;
  logic [WIDTH:0]   sum_d;
  logic             ovf_d;
  logic [WIDTH:0]   sum_q;
  logic             ovf_q;
  logic             valid_q;

  assign carry[0] = 1'b0;

  // One full-adder cell per operand bit; carry[i+1] feeds the next stage.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder_cell u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (s_bits[i]),
      .cout (carry[i+1])
    );
  end

  // Assemble the full-precision result and the two's-complement overflow flag.
  // Overflow occurs when the carry into the MSB differs from the carry out of it.
  always_comb begin
    sum_d = {carry[WIDTH], s_bits};
    ovf_d = carry[WIDTH] ^ carry[WIDTH-1];
  end

  // Capture on in_valid; hold the result otherwise. The asynchronous reset discards any
  // result arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q <= sum_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign sum        = sum_q;
  assign signed_ovf = ovf_q;
  assign out_valid  = valid_q;

endmodule

// File: tb/tb_binary_adder.sv
// Scoreboard bench for binary_adder (WIDTH = 4): the driver pushes expected results, and a
// monitor pops and compares them whenever out_valid is seen.
module tb_binary_adder;

  localparam int unsigned W = 4;

  typedef struct {
    logic [W:0] sum;
    logic       ovf;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         in_valid;
  logic [W:0]   sum;
  logic         out_valid;
  logic         signed_ovf;

  exp_t       exp_q[$];
  logic [W:0] last_sum;
  logic       last_ovf;
  int         n_checks;
  int         n_errors;

  binary_adder #(
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .in_valid   (in_valid),
    .sum        (sum),
    .out_valid  (out_valid),
    .signed_ovf (signed_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model in plain integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int   ua;
    int   ub;
    int   sa;
    int   sb;
    int   total;
    ua = int'(av);
    ub = int'(bv);
    sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    total = ua + ub;
    e.sum = total[W:0];
    e.ovf = ((sa + sb) > ((1 << (W - 1)) - 1)) || ((sa + sb) < -(1 << (W - 1)));
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one beat on the falling edge; queue its expected result when valid.
  task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic v);
    @(negedge clk);
    a        = av;
    b        = bv;
    in_valid = v;
    if (v) exp_q.push_back(model(av, bv));
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ovf", 32'(signed_ovf), 32'd0);
        last_sum = '0;
        last_ovf = 1'b0;
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sum", 32'(sum), 32'(e.sum));
          check("signed_ovf", 32'(signed_ovf), 32'(e.ovf));
          last_sum = e.sum;
          last_ovf = e.ovf;
        end
      end else begin
        check("hold_sum", 32'(sum), 32'(last_sum));
        check("hold_ovf", 32'(signed_ovf), 32'(last_ovf));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    last_sum = '0;
    last_ovf = 1'b0;
    rst      = 1'b0;
    a        = 4'hF;
    b        = 4'hF;
    in_valid = 1'b1;

    // Reset asserted between edges with live operands; must clear at once and hold.
    #1 rst = 1'b1;
    #1;
    check("rst_async_sum", 32'(sum), 32'd0);
    check("rst_async_valid", 32'(out_valid), 32'd0);
    check("rst_async_ovf", 32'(signed_ovf), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;

    // Directed: zero, mixed, max, signed overflow, then capture-and-hold.
    drive(4'h0, 4'h0, 1'b1);
    drive(4'hA, 4'h6, 1'b1);
    drive(4'hF, 4'hF, 1'b1);
    drive(4'h7, 4'h1, 1'b1);
    drive(4'h3, 4'h4, 1'b1);
    repeat (3) drive(4'h9, 4'h9, 1'b0);

    // Back-to-back full-rate traffic.
    for (int i = 0; i < 16; i++) drive(4'(i), 4'(15 - i), 1'b1);

    // Second stream with an asynchronous reset dropped in between edges.
    for (int i = 0; i < 16; i++) begin
      drive(4'(i), 4'(15 - i), 1'b1);
      if (i == 8) begin
        #2 rst = 1'b1;
        #1;
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ovf", 32'(signed_ovf), 32'd0);
        exp_q.delete();
        last_sum = '0;
        last_ovf = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        break;
      end
    end
    drive(4'h5, 4'h6, 1'b1);
    drive(4'h0, 4'h0, 1'b0);

    // Random traffic with random gaps.
    for (int i = 0; i < 300; i++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0));
    end

    drive(4'h0, 4'h0, 1'b0);
    drive(4'h0, 4'h0, 1'b0);
    @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/binary_adder.md
Name: binary_adder

Overview:
- Registered unsigned adder: two WIDTH-bit operands in, a WIDTH+1-bit sum out, carry kept as the MSB.
- Datapath is a structural ripple-carry chain of full-adder cells.
- The result is captured in an output register on a valid strobe.
- Used as a small arithmetic leaf in datapaths that need a full-precision sum with one-cycle latency.

Parameters:
- WIDTH, 4, operand width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- in_valid  input  1  a and b are valid this cycle
- sum  output  WIDTH+1  registered a+b; sum[WIDTH] is the carry-out
- out_valid  output  1  sum was updated on the last rising edge
- signed_ovf  output  1  registered two's-complement overflow flag for the same addition

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports clk, rst).
- Reset:
  - rst=1 immediately, without waiting for a clock edge, forces sum=0, out_valid=0, signed_ovf=0.
  - Outputs hold these values while rst is high.
  - First capture is possible on the first rising edge after rst deasserts.
- Arithmetic:
  - sum = zero-extended a + zero-extended b, computed at full WIDTH+1 precision.
  - No wrap and no saturation. Example: 4'hF + 4'hF = 5'b11110.
- Carry chain:
  - Bit i: s[i] = a[i]^b[i]^c[i]; c[i+1] = majority(a[i],b[i],c[i]); c[0]=0.
  - sum[WIDTH] = c[WIDTH].
- Signed overflow: signed_ovf = c[WIDTH]^c[WIDTH-1]. It is computed from the same operands and registered together with sum.
- Capture:
  - On a rising edge with in_valid=1, sum and signed_ovf load the new result and out_valid becomes 1.
  - On a rising edge with in_valid=0, sum and signed_ovf hold their previous values and out_valid becomes 0.
- Latency: 1 cycle; operands sampled at edge N appear on sum after edge N.
- Throughput: one addition per cycle. Back-to-back in_valid is fully supported, with no stall or backpressure.
- Timing: outputs are register-only. No combinational path from inputs to outputs.
- Reset mid-operation: a result being captured in the same cycle rst asserts is discarded. Outputs go to zero asynchronously.
- X-handling: none required. The bench must drive a and b to known values whenever in_valid=1.

Decomposition:
- Shared package binary_adder_pkg:
  - constant DEFAULT_WIDTH=4
  - function computing the reference sum for benches (zero-extend and add)
- Sub-module full_adder_cell:
  - inputs a, b, cin; outputs s, cout
  - instantiated WIDTH times by a generate loop to form the ripple chain
- Top-level binary_adder:
  - owns the generate loop, overflow logic and output registers

Test Plan:
- Reset: rst=1 for 2 cycles with a=4'hF, b=4'hF, in_valid=1 -> sum=5'b00000, out_valid=0, signed_ovf=0 throughout reset.
- Zero then mixed, after reset:
  - a=0, b=0, in_valid=1 -> next cycle sum=5'b00000, out_valid=1.
  - Then a=4'b1010, b=4'b0110 -> sum=5'b10000, signed_ovf=0.
- Max operands: a=4'hF, b=4'hF -> sum=5'b11110, signed_ovf=0. Then a=4'h7, b=4'h1 -> sum=5'b01000, signed_ovf=1.
- Hold: capture a=3, b=4 (sum=7). Drive in_valid=0 with a=9, b=9 for 3 cycles -> sum stays 5'b00111, out_valid=0.
- Back-to-back: in_valid=1 for 16 consecutive cycles with a=i, b=15-i -> every following cycle sum=5'b01111, out_valid=1.
- Async reset mid-stream: assert rst between clock edges during back-to-back traffic -> sum and out_valid go to 0 before the next edge. After release, the first in_valid edge produces the correct sum.
